mux_select_arbiter: RTL and testbench
=====================================

MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8: maximum cycles a grant may be held when ARB_TIMEOUT_EN is defined; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request per mux input; bit i requests in<i> of the downstream 4:1 mux.
REQ-005 done  input  1  current owner finished; releases the grant.
REQ-006 select  output  2  registered mux select driving the downstream 4:1 mux.
REQ-007 grant  output  4  registered one-hot grant; bit i is set iff valid=1 and select=i.
REQ-008 valid  output  1  registered; 1 while select names an active owner.
REQ-009 timeout  output  1  registered one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 IDLE, req != 0: next edge -> GRANT, select = first set req bit scanning ptr, ptr+1, ... mod 4; valid=1; grant one-hot; latency 1 cycle.
REQ-012 IDLE, req == 0: stay IDLE; valid=0; grant=0; select holds its last value.
REQ-013 GRANT: hold select/grant/valid while req[select]=1 and done=0; changes on other req bits SHALL be ignored.
REQ-014 GRANT, done=1 or req[select]=0: next edge -> IDLE; valid=0; grant=0; select unchanged; ptr = select+1 mod 4.
REQ-015 Pointer SHALL wrap 3 -> 0; ptr is 2 bits.
REQ-016 Minimum one IDLE cycle between consecutive grants; no back-to-back grants.
REQ-017 done while IDLE SHALL be ignored.
REQ-018 done=1 and req[select]=0 in the same cycle SHALL give a single normal release; timeout=0.
REQ-019 A requester re-asserting req in its release cycle SHALL lose priority to any other pending requester (ptr rule).

Reset
REQ-020 rst_n=0 SHALL immediately force: state IDLE, select=0, grant=0, valid=0, timeout=0, ptr=0, hold counter=0.
REQ-021 Reset asserted mid-grant SHALL drop valid/grant without waiting for a clock edge; no release bookkeeping is retained.
REQ-022 First arbitration after rst_n deasserts SHALL start scanning from index 0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN: when defined, a 4-bit hold counter SHALL clear on entering GRANT and increment each GRANT cycle.
REQ-024 With ARB_TIMEOUT_EN: counter reaching MAX_HOLD-1 with req[select]=1 and done=0 SHALL force release on the next edge (as REQ-014) and pulse timeout=1 for exactly that cycle.
REQ-025 Without ARB_TIMEOUT_EN: no counter is built; grants are held indefinitely; timeout is tied to 0.

Verification
REQ-026 Reset, req=4'b0000, 5 cycles -> select=00, grant=0000, valid=0 throughout.
REQ-027 req=4'b1010 from reset -> after 1 edge select=01, grant=0010, valid=1; done=1 one cycle -> valid=0; next grant select=11, grant=1000.
REQ-028 All req=4'b1111 held, done pulsed after each grant -> select sequence 00,01,10,11,00 (wrap), one idle cycle between grants.
REQ-029 Grant to 10, then req[2] drops with req=4'b0001 -> release next edge, then select=00, grant=0001.
REQ-030 rst_n pulled low mid-grant (select=11) between edges -> valid=0, grant=0000, select=00 immediately; after release, req=4'b1000 -> select=11.
REQ-031 ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0100 held, done=0 -> valid high 4 cycles, timeout=1 for 1 cycle at release; without the macro valid stays 1 for 20+ cycles and timeout=0.

Source files
------------

// File: rtl/mux_select_arbiter.sv
// Round-robin select arbiter for a downstream 4:1 mux: registered select/grant/valid, one idle cycle between grants.
// Optional hold-time limit with forced release and timeout pulse is enabled by defining ARB_TIMEOUT_EN.
module mux_select_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] select,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_select;
    logic [1:0] r_ptr;
    logic [3:0] r_grant;
    logic       r_valid;

    logic [1:0] w_pick;
    logic       w_normal_rel;
    logic       w_force;
    logic       w_release;

    // First requester at or after the round-robin pointer, wrapping modulo 4.
    function automatic logic [1:0] f_scan(input logic [3:0] req_v, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + k[1:0];
            if (!found && req_v[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("mux_select_arbiter: MAX_HOLD must be in 2..15");
    end

    assign w_pick       = f_scan(req, r_ptr);
    assign w_normal_rel = done || !req[r_select];
    assign w_release    = w_normal_rel || w_force;

`ifdef ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [3:0] r_hold;
    logic       r_timeout;

    assign w_force = (r_state == S_GRANT) && (r_hold == HOLD_LAST) && !w_normal_rel;

    // Hold counter runs only while granted; timeout pulses for the cycle after a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= 4'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (r_state == S_GRANT) begin
                r_hold <= r_hold + 4'd1;
            end else begin
                r_hold <= 4'd0;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    // Arbitration FSM; the pointer advances past the owner on every release so a re-request loses priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_select <= 2'd0;
            r_ptr    <= 2'd0;
            r_grant  <= 4'd0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state  <= S_GRANT;
                        r_select <= w_pick;
                        r_grant  <= f_onehot(w_pick);
                        r_valid  <= 1'b1;
                    end else begin
                        r_grant <= 4'd0;
                        r_valid <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state <= S_IDLE;
                        r_grant <= 4'd0;
                        r_valid <= 1'b0;
                        r_ptr   <= r_select + 2'd1;
                    end else begin
                        r_grant <= f_onehot(r_select);
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 4'd0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign select = r_select;
    assign grant  = r_grant;
    assign valid  = r_valid;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed scoreboard bench for mux_select_arbiter; covers the timed-release build when ARB_TIMEOUT_EN is defined.
module tb_mux_select_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_MAX_HOLD = 4;
`else
    localparam int unsigned TB_MAX_HOLD = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] select;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    mux_select_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .select (select),
        .grant  (grant),
        .valid  (valid),
        .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output vector {select, grant, valid, timeout}; grant is derived from select and valid.
    function automatic logic [7:0] exp_v(input logic [1:0] sel, input logic vld, input logic to);
        logic [3:0] g;
        g = vld ? (4'b0001 << sel) : 4'b0000;
        return {sel, g, vld, to};
    endfunction

    task automatic compare(input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {select, grant, valid, timeout};
        exp = sb.pop_front();
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag, input logic [7:0] e);
        sb.push_back(e);
        compare(tag);
    endtask

    task automatic cyc(input string tag, input logic [3:0] r, input logic d, input logic [7:0] e);
        req  = r;
        done = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset", exp_v(2'd0, 1'b0, 1'b0));
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) cyc("idle_noreq", 4'b0000, 1'b0, exp_v(2'd0, 1'b0, 1'b0));

        cyc("r1010_g1",  4'b1010, 1'b0, exp_v(2'd1, 1'b1, 1'b0));
        cyc("r1010_rel", 4'b1010, 1'b1, exp_v(2'd1, 1'b0, 1'b0));
        cyc("r1010_g3",  4'b1010, 1'b0, exp_v(2'd3, 1'b1, 1'b0));
        cyc("r1010_rel3",4'b1010, 1'b1, exp_v(2'd3, 1'b0, 1'b0));

        cyc("rr_g0",   4'b1111, 1'b0, exp_v(2'd0, 1'b1, 1'b0));
        cyc("rr_i0",   4'b1111, 1'b1, exp_v(2'd0, 1'b0, 1'b0));
        cyc("rr_g1",   4'b1111, 1'b0, exp_v(2'd1, 1'b1, 1'b0));
        cyc("rr_i1",   4'b1111, 1'b1, exp_v(2'd1, 1'b0, 1'b0));
        cyc("rr_g2",   4'b1111, 1'b0, exp_v(2'd2, 1'b1, 1'b0));
        cyc("rr_i2",   4'b1111, 1'b1, exp_v(2'd2, 1'b0, 1'b0));
        cyc("rr_g3",   4'b1111, 1'b0, exp_v(2'd3, 1'b1, 1'b0));
        cyc("rr_i3",   4'b1111, 1'b1, exp_v(2'd3, 1'b0, 1'b0));
        cyc("rr_wrap", 4'b1111, 1'b0, exp_v(2'd0, 1'b1, 1'b0));
        cyc("rr_iw",   4'b1111, 1'b1, exp_v(2'd0, 1'b0, 1'b0));

        cyc("drop_g2",  4'b0100, 1'b0, exp_v(2'd2, 1'b1, 1'b0));
        cyc("drop_rel", 4'b0001, 1'b0, exp_v(2'd2, 1'b0, 1'b0));
        cyc("drop_g0",  4'b0001, 1'b0, exp_v(2'd0, 1'b1, 1'b0));
        cyc("drop_i0",  4'b0000, 1'b0, exp_v(2'd0, 1'b0, 1'b0));

        cyc("rereq_g1",  4'b0010, 1'b0, exp_v(2'd1, 1'b1, 1'b0));
        cyc("rereq_rel", 4'b0011, 1'b1, exp_v(2'd1, 1'b0, 1'b0));
        cyc("rereq_g0",  4'b0011, 1'b0, exp_v(2'd0, 1'b1, 1'b0));
        cyc("rereq_i0",  4'b0000, 1'b0, exp_v(2'd0, 1'b0, 1'b0));

        cyc("both_g2",   4'b0100, 1'b0, exp_v(2'd2, 1'b1, 1'b0));
        cyc("both_rel",  4'b0000, 1'b1, exp_v(2'd2, 1'b0, 1'b0));
        cyc("done_idle", 4'b0000, 1'b1, exp_v(2'd2, 1'b0, 1'b0));
        cyc("done_g2",   4'b0100, 1'b1, exp_v(2'd2, 1'b1, 1'b0));
        cyc("done_rel",  4'b0100, 1'b1, exp_v(2'd2, 1'b0, 1'b0));

        cyc("hold_g3", 4'b1000, 1'b0, exp_v(2'd3, 1'b1, 1'b0));
        cyc("hold_a",  4'b1111, 1'b0, exp_v(2'd3, 1'b1, 1'b0));
        cyc("hold_b",  4'b1001, 1'b0, exp_v(2'd3, 1'b1, 1'b0));

        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst", exp_v(2'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check_now("rst_held", exp_v(2'd0, 1'b0, 1'b0));
        rst_n = 1'b1;
        cyc("post_rst_g3",  4'b1000, 1'b0, exp_v(2'd3, 1'b1, 1'b0));
        cyc("post_rst_rel", 4'b1000, 1'b1, exp_v(2'd3, 1'b0, 1'b0));

        cyc("long_g2", 4'b0100, 1'b0, exp_v(2'd2, 1'b1, 1'b0));
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < TB_MAX_HOLD; i++) cyc("long_hold", 4'b0100, 1'b0, exp_v(2'd2, 1'b1, 1'b0));
        cyc("to_pulse", 4'b0100, 1'b0, exp_v(2'd2, 1'b0, 1'b1));
        cyc("to_clear", 4'b0000, 1'b0, exp_v(2'd2, 1'b0, 1'b0));
`else
        for (int i = 0; i < 22; i++) cyc("long_hold", 4'b0100, 1'b0, exp_v(2'd2, 1'b1, 1'b0));
        cyc("long_rel", 4'b0100, 1'b1, exp_v(2'd2, 1'b0, 1'b0));
        cyc("long_idle", 4'b0000, 1'b0, exp_v(2'd2, 1'b0, 1'b0));
`endif

        #2;
        rst_n = 1'b0;
        #1;
        check_now("rst2", exp_v(2'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("scan_from0", 4'b1111, 1'b0, exp_v(2'd0, 1'b1, 1'b0));

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
